// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - iterative AES inverse-cipher round engine with lane-parallel InvSubBytes
// Round order: InvShiftRows, InvSubBytes (LANES bytes per cycle), AddRoundKey, InvMixColumns.

package aes_inv_round_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

module inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    import aes_inv_round_pkg::*;

    // Inverse affine transform, then multiplicative inverse as a^254 (maps 0 to 0).
    logic [7:0] aff;
    logic [7:0] sq;
    logic [7:0] inv;

    always_comb begin
        aff = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
        sq  = aff;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        dout = inv;
    end

endmodule

module aes_inv_round #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] rkey_in,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);
    import aes_inv_round_pkg::*;

    localparam int N  = (LANES > 0) ? 16 / LANES : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_round: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [127:0]      s_reg;
    logic [127:0]      key_reg;
    logic              last_reg;
    logic [127:0]      t;
    logic [8*LANES-1:0] sub_in;
    logic [8*LANES-1:0] sub_out;

    // Byte i lives at [127-8i -: 8]; row = i%4, col = i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127-8*(4*c)   -: 8];
            a1 = v[127-8*(4*c+1) -: 8];
            a2 = v[127-8*(4*c+2) -: 8];
            a3 = v[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Lane j works on byte cnt*LANES + j of the shifted state.
    always_comb begin
        sub_in = '0;
        for (int j = 0; j < LANES; j++) begin
            sub_in[8*j +: 8] = s_reg[127-8*(int'(cnt)*LANES+j) -: 8];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        inv_sbox u_inv_sbox (
            .din  (sub_in[8*j +: 8]),
            .dout (sub_out[8*j +: 8])
        );
    end

    assign t = s_reg ^ key_reg;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nx = SUB;
            end
            SUB: begin
                if (cnt == CW'(N-1)) state_nx = MIX;
            end
            MIX: begin
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            s_reg     <= '0;
            key_reg   <= '0;
            last_reg  <= 1'b0;
            state_out <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_reg    <= inv_shift_rows(state_in);
                        key_reg  <= rkey_in;
                        last_reg <= last_round;
                        cnt      <= '0;
                    end
                end
                SUB: begin
                    for (int j = 0; j < LANES; j++) begin
                        s_reg[127-8*(int'(cnt)*LANES+j) -: 8] <= sub_out[8*j +: 8];
                    end
                    // Counter parks at N-1 rather than wrapping.
                    if (cnt != CW'(N-1)) cnt <= cnt + 1'b1;
                end
                MIX: begin
                    state_out <= last_reg ? t : inv_mix_columns(t);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round.sv
// tb/tb_aes_inv_round.sv - table-driven bench for aes_inv_round across all legal LANES values
module tb_aes_inv_round;

    localparam int NI = 5;
    localparam int LV [NI] = '{1, 2, 4, 8, 16};
    localparam int L4 = 2;

    typedef struct {
        logic [127:0] s;
        logic [127:0] k;
        logic         l;
        logic [127:0] e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          last_round;
    logic          out_ready;
    logic [127:0]  state_in;
    logic [127:0]  rkey_in;
    logic [NI-1:0] in_ready_v;
    logic [NI-1:0] out_valid_v;
    logic [127:0]  state_out_v [NI];

    int checks = 0;
    int errors = 0;
    vec_t tbl [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_inv_round #(.LANES(LV[g])) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready_v[g]),
            .state_in   (state_in),
            .rkey_in    (rkey_in),
            .last_round (last_round),
            .out_valid  (out_valid_v[g]),
            .out_ready  (out_ready),
            .state_out  (state_out_v[g])
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with every instance idle; leaves them idle.
    task automatic run_vec(input vec_t v, input string tag);
        int  lat [NI];
        int  k;
        logic [NI-1:0] seen;
        seen = '0;
        for (int i = 0; i < NI; i++) lat[i] = -1;
        chk($sformatf("%s in_ready_before", tag), 128'(in_ready_v), 128'({NI{1'b1}}));
        state_in   = v.s;
        rkey_in    = v.k;
        last_round = v.l;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        step();
        in_valid   = 1'b0;
        state_in   = ~v.s;
        rkey_in    = ~v.k;
        last_round = ~v.l;
        k = 0;
        while (k < 30 && seen != {NI{1'b1}}) begin
            step();
            k++;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && out_valid_v[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = k;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s L%0d latency", tag, LV[i]), 128'(lat[i]), 128'(16 / LV[i] + 1));
            chk($sformatf("%s L%0d state_out", tag, LV[i]), state_out_v[i], v.e);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            step();
            chk($sformatf("%s stall%0d out_valid", tag, c), 128'(out_valid_v), 128'({NI{1'b1}}));
            chk($sformatf("%s stall%0d in_ready", tag, c), 128'(in_ready_v), 128'(0));
            chk($sformatf("%s stall%0d state_out", tag, c), state_out_v[L4], v.e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk($sformatf("%s post_hs out_valid", tag), 128'(out_valid_v), 128'(0));
        chk($sformatf("%s post_hs in_ready", tag), 128'(in_ready_v), 128'({NI{1'b1}}));
        chk($sformatf("%s post_hs state_out_held", tag), state_out_v[L4], v.e);
    endtask

    initial begin
        int acc_n;
        int out_n;
        int last_acc;
        int cyc;
        logic acc;
        logic done;
        logic [127:0] so;

        tbl[0] = '{s: 128'h6353e08c0960e104cd70b751bacad0e7,
                   k: 128'h000102030405060708090a0b0c0d0e0f,
                   l: 1'b1,
                   e: 128'h00112233445566778899aabbccddeeff};
        tbl[1] = '{s: 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                   k: 128'h549932d1f08557681093ed9cbe2c974e,
                   l: 1'b0,
                   e: 128'h54d990a16ba09ab596bbf40ea111702f};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        last_round = 1'b0;
        state_in   = '0;
        rkey_in    = '0;
        step();
        step();
        chk("reset in_ready", 128'(in_ready_v), 128'(0));
        chk("reset out_valid", 128'(out_valid_v), 128'(0));
        for (int i = 0; i < NI; i++) chk($sformatf("reset L%0d state_out", LV[i]), state_out_v[i], 128'(0));
        rst_n = 1'b1;
        #1;
        chk("reset release in_ready", 128'(in_ready_v), 128'({NI{1'b1}}));
        step();

        for (int v = 0; v < 2; v++) run_vec(tbl[v], $sformatf("vec%0d", v));

        // Abandon a round mid-SUB with a one-cycle reset pulse.
        state_in   = tbl[1].s;
        rkey_in    = tbl[1].k;
        last_round = tbl[1].l;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midsub in_ready_in_reset", 128'(in_ready_v), 128'(0));
        step();
        chk("midsub out_valid", 128'(out_valid_v), 128'(0));
        for (int i = 0; i < NI; i++) chk($sformatf("midsub L%0d state_out", LV[i]), state_out_v[i], 128'(0));
        rst_n = 1'b1;
        #1;
        chk("midsub release in_ready", 128'(in_ready_v), 128'({NI{1'b1}}));
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("midsub quiet%0d out_valid", c), 128'(out_valid_v), 128'(0));
        end
        run_vec(tbl[0], "after_reset");

        // Back-to-back rounds on the LANES=4 instance with in_valid and out_ready held high.
        acc_n    = 0;
        out_n    = 0;
        last_acc = -1;
        cyc      = 0;
        state_in   = tbl[0].s;
        rkey_in    = tbl[0].k;
        last_round = tbl[0].l;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        while (out_n < 4 && cyc < 100) begin
            acc  = in_ready_v[L4] && in_valid;
            done = out_valid_v[L4];
            so   = state_out_v[L4];
            step();
            cyc++;
            if (done) begin
                chk($sformatf("b2b out%0d", out_n), so, tbl[out_n % 2].e);
                out_n++;
            end
            if (acc) begin
                if (acc_n > 0) chk($sformatf("b2b interval%0d", acc_n), 128'(cyc - last_acc), 128'(7));
                last_acc = cyc;
                acc_n++;
                if (acc_n < 4) begin
                    state_in   = tbl[acc_n % 2].s;
                    rkey_in    = tbl[acc_n % 2].k;
                    last_round = tbl[acc_n % 2].l;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b outputs_seen", 128'(out_n), 128'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
